// File: rtl/fp_sum_seq.sv
// fp_sum_seq: folds a valid/ready stream of binary32 operands into one sum per
// vector by sequencing two-operand additions on an external fp_add_sub.
module fp_sum_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] add_a1,
  output logic [31:0] add_a2,
  output logic        add_start,
  output logic        add_reset,
  input  logic [31:0] add_result,
  input  logic        add_done,
  output logic [31:0] sum_out,
  output logic        sum_valid,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_CLR, S_FLUSH, S_EMIT
  } state_t;

  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  logic [31:0]   head_data;
  logic          head_last;

  state_t        state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   a1_q, a1_d, a2_q, a2_d;
  logic [31:0]   sum_out_q, sum_out_d;
  logic          sum_valid_q, sum_valid_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic          abort_q, abort_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full && !reset;
  assign head_data = mem_q[rd_ptr_q][31:0];
  assign head_last = mem_q[rd_ptr_q][32];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    sum_out_d   = sum_out_q;
    sum_valid_d = 1'b0;
    err_d       = err_q;
    last_d      = last_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          acc_d   = head_data;
          state_d = head_last ? S_EMIT : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!empty) begin
          pop     = 1'b1;
          a1_d    = acc_q;
          a2_d    = head_data;
          last_d  = head_last;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (add_done) begin
          acc_d   = add_result;
          state_d = S_CLR;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_CLR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLR: begin
        // The adder is cleared after every add, so the next start never overlaps it.
        if (abort_q && !last_q) begin
          state_d = S_FLUSH;
        end else if (abort_q) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else if (last_q) begin
          state_d = S_EMIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FLUSH: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_last) begin
            abort_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        sum_out_d   = acc_q;
        sum_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      acc_q       <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      sum_out_q   <= sum_out_d;
      sum_valid_q <= sum_valid_d;
      err_q       <= err_d;
      last_q      <= last_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
    end
  end

  assign add_a1    = a1_q;
  assign add_a2    = a2_q;
  assign add_start = (state_q == S_ISSUE);
  assign add_reset = reset || (state_q == S_CLR);
  assign sum_out   = sum_out_q;
  assign sum_valid = sum_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/fp_sum_seq.md
Name: fp_sum_seq

Overview:
- Upstream sequencer for fp_add_sub. Reduces a stream of IEEE-754 single-precision values into one sum by issuing repeated two-operand additions to the adder.
- Operands arrive on a valid/ready stream with a `last` marker and are buffered in a small FIFO.
- Runs the adder's start/done/reset handshake and emits one sum per vector.

Parameters:
- DEPTH, 4, input FIFO depth in entries (power of two, ≥2)
- TIMEOUT, 64, max cycles waited for add_done before abort (≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  32  operand (binary32)
- in_valid  in  1  in_data/in_last valid
- in_last  in  1  final element of current vector
- in_ready  out  1  FIFO can accept; equals !full
- add_a1  out  32  to adder a1 (accumulator)
- add_a2  out  32  to adder a2 (new element)
- add_start  out  1  one-cycle start pulse to adder
- add_reset  out  1  to adder reset; equals reset OR internal clear pulse
- add_result  in  32  adder result
- add_done  in  1  adder done
- sum_out  out  32  completed vector sum, held until next sum
- sum_valid  out  1  one-cycle pulse, sum_out new
- err  out  1  sticky timeout flag, cleared only by reset
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: FIFO empty, state IDLE.
  - add_a1, add_a2, sum_out, acc: 0.
  - add_start, sum_valid, err, busy: 0.
  - add_reset: 1 while reset is high.
- FIFO entries are 33 bits {last, data}.
  - Push when in_valid && in_ready && !reset.
  - Pop only in IDLE, FETCH or FLUSH when not empty.
  - Pointers wrap modulo DEPTH; a separate count distinguishes full from empty.
  - Push and pop in the same cycle are both allowed and leave the count unchanged.
  - When full, in_ready=0 and no push occurs.
- States:
  - IDLE: if FIFO not empty, pop e; acc<=e.data.
    - If e.last, go to EMIT (single-element vector, no add issued).
    - Otherwise go to FETCH.
  - FETCH: if FIFO not empty, pop e; add_a1<=acc; add_a2<=e.data; last_r<=e.last; go to ISSUE. Otherwise stay.
  - ISSUE: add_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: add_a1/add_a2 are held stable.
    - On add_done: acc<=add_result; go to CLR.
    - Otherwise increment the counter. When it reaches TIMEOUT-1: err<=1, set abort_r, go to CLR.
  - CLR: internal clear pulse for one cycle (add_reset=1). Next state:
    - abort_r && !last_r: FLUSH.
    - abort_r && last_r: IDLE (abort_r cleared).
    - last_r: EMIT.
    - otherwise: FETCH.
  - FLUSH: pop and discard entries until an entry with last=1 is popped; then clear abort_r and go to IDLE. No sum is emitted for an aborted vector.
  - EMIT: sum_out<=acc; sum_valid=1 for one cycle; go to IDLE.
- Arithmetic: no arithmetic in this block. The adder result is taken verbatim, including signed zero and special values.
- Minimum add cost: ISSUE + WAIT(adder latency) + CLR. The next add_start never occurs in the same cycle as add_reset.
- add_done seen in any state other than WAIT is ignored.
- Reset mid-operation: returns to IDLE next cycle and discards FIFO contents, acc and any partial sum; add_reset is high for the adder.
- in_last=1 with no preceding element forms a one-element vector.

Test Plan:
1. Two-element vector 0x3FE00000 (1.75), 0x40500000 (last) with real fp_add_sub -> one add_start with a1=0x3FE00000, a2=0x40500000; one add_reset pulse after done; sum_valid once with sum_out=0x40A00000.
2. Three-element vector 0x3FE00000, 0x40500000, 0xBFE00000 (last) -> exactly two add_start pulses; sum_out=0x40500000.
3. Single-element vector 0x43E42666 (last) -> no add_start; sum_valid with sum_out=0x43E42666 within 3 cycles of push.
4. Backpressure: stub adder withholds done for 20 cycles; push 7 elements back-to-back with DEPTH=4 -> in_ready drops to 0 once 4 are buffered; no element lost or duplicated; final sum is correct.
5. Timeout: stub adder never asserts done, TIMEOUT=16, vector of 3 -> err=1 after 16 WAIT cycles; one add_reset pulse; remaining elements drained; no sum_valid. The next vector 0x3FE00000, 0x40500000 still sums to 0x40A00000 with err still 1.
6. Reset asserted in WAIT -> add_reset high that cycle; busy=0 next cycle; FIFO empty; no sum_valid; err=0.
